// File: rtl/seq_divider_unit.sv
// Sequential restoring divider: one quotient bit per cycle, signed or unsigned operands,
// results in truncate-toward-zero form with a divide-by-zero flag.
module seq_divider_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  dvd_q, dvd_d;  // dividend shifts out as quotient bits shift in
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  rmd_q, rmd_d;
  logic              dbz_q, dbz_d;

  logic              dvd_neg, dvs_neg;
  logic [WIDTH-1:0]  dvd_abs, dvs_abs;
  logic [WIDTH:0]    shifted;
  logic              fits;

  always_comb begin
    dvd_neg = is_signed_i & dividend_i[WIDTH-1];
    dvs_neg = is_signed_i & divisor_i[WIDTH-1];
    dvd_abs = dvd_neg ? -dividend_i : dividend_i;
    dvs_abs = dvs_neg ? -divisor_i : divisor_i;
    shifted = {rem_q, dvd_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvs_q});
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    dbz_d     = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (divisor_i == '0) begin
            quo_d   = '1;
            rmd_d   = dividend_i;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            dvd_d     = dvd_abs;
            dvs_d     = dvs_abs;
            rem_d     = '0;
            cnt_d     = CntW'(WIDTH);
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
            state_d   = StIter;
          end
        end
      end
      StIter: begin
        if (fits) begin
          rem_d = WIDTH'(shifted - {1'b0, dvs_q});
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        // Most-negative / -1 falls out naturally: |q| = 2^(WIDTH-1) reads as most-negative.
        quo_d   = neg_quo_q ? -dvd_q : dvd_q;
        rmd_d   = neg_rem_q ? -rem_q : rem_q;
        dbz_d   = 1'b0;
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rmd_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      rmd_q     <= rmd_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
  assign quotient_o    = quo_q;
  assign remainder_o   = rmd_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: doc/seq_divider_unit.md
SEQ_DIVIDER_UNIT -- requirements
Module: seq_divider_unit

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 32, giving the operand and result width in bits (legal range 4..64).
REQ-002 Clock  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 Clear  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request a division; it is sampled only in IDLE.
REQ-005 is_signed  input  1  SHALL select two's-complement (1) or unsigned (0) division; it is sampled with start.
REQ-006 dividend  input  WIDTH  SHALL carry the numerator; it is sampled with start.
REQ-007 divisor  input  WIDTH  SHALL carry the denominator; it is sampled with start.
REQ-008 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-009 done  output  1  SHALL pulse high for exactly one cycle when results are updated.
REQ-010 quotient  output  WIDTH  SHALL carry the registered quotient (LO destination).
REQ-011 remainder  output  WIDTH  SHALL carry the registered remainder (HI destination).
REQ-012 div_by_zero  output  1  SHALL be the registered flag for the last completed operation; it is valid while done is high and holds afterwards.

Function
REQ-013 The state machine SHALL have four states: IDLE, ITER, FIX and DONE.
REQ-014 In IDLE, when start=1 and divisor!=0, the block SHALL latch |dividend| and |divisor| into working registers, latch sign flags, load the iteration counter with WIDTH, clear the partial remainder and go to ITER.
- Absolute values are taken only when is_signed=1; otherwise operands are used raw.
REQ-015 In IDLE, when start=1 and divisor==0, the block SHALL go directly to DONE with quotient=all-ones, remainder=dividend and div_by_zero=1.
REQ-016 Each ITER cycle SHALL perform one restoring-division step:
- shift {remainder, dividend-work} left by 1;
- trial subtract the divisor;
- if the result is non-negative, keep it and set the quotient bit to 1; otherwise restore.
- decrement the counter.
REQ-017 ITER SHALL last exactly WIDTH cycles; when the counter reaches 0, the block SHALL go to FIX.
REQ-018 In FIX, if is_signed was latched as 1:
- the quotient SHALL be negated when the dividend and divisor signs differ;
- the remainder SHALL be negated when the dividend was negative.
This gives truncation toward zero, with the remainder taking the sign of the dividend. FIX then goes to DONE.
REQ-019 In DONE, the block SHALL drive the results to the outputs and hold done=1 for one cycle, then return to IDLE; div_by_zero SHALL be 0 for every non-zero divisor.
REQ-020 Latency from the start-sampling edge to done high SHALL be WIDTH+2 cycles for a non-zero divisor, and 1 cycle for divisor==0.
REQ-021 A start asserted while busy=1 SHALL be ignored, with no queuing; start held high in IDLE after DONE SHALL begin a new operation.
REQ-022 The signed overflow case (most-negative / -1) SHALL yield quotient=most-negative and remainder=0, with no flag.
REQ-023 quotient, remainder and div_by_zero SHALL hold their last values until the next DONE.
REQ-024 Input changes during busy SHALL NOT affect the operation in progress.

Reset
REQ-025 Clear=0 SHALL immediately force:
- state to IDLE;
- busy=0, done=0, div_by_zero=0;
- quotient=0, remainder=0;
- the counter and all working registers to 0.
REQ-026 A reset during ITER or FIX SHALL abort the operation, and no done SHALL follow.
REQ-027 After Clear returns to 1, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-028 Unsigned 780/40 (WIDTH=32) -> after 34 cycles: done=1, quotient=19, remainder=20, div_by_zero=0.
REQ-029 Signed -780/40 -> quotient=0xFFFFFFED (-19), remainder=0xFFFFFFEC (-20); signed 780/-40 -> quotient=0xFFFFFFED, remainder=20.
REQ-030 Divide by zero, 7/0 -> done after 1 cycle, quotient=0xFFFFFFFF, remainder=7, div_by_zero=1.
REQ-031 Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned 0xFFFFFFFF/2 -> quotient=0x7FFFFFFF, remainder=1.
REQ-032 Start a division, pulse start again at cycle 5, then pulse Clear low at cycle 10 -> the second start is ignored, busy=0 immediately on Clear, no done pulse, and outputs read 0; a subsequent 100/7 -> quotient=14, remainder=2.
REQ-033 WIDTH=8, unsigned 200/3 -> quotient=66, remainder=2, with done 10 cycles after the start edge.
